// File: rtl/spi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_pkg : shared types and defaults for the SPI slave shifter     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  localparam int SPI_DATA_W = 8;
  localparam logic [SPI_DATA_W-1:0] SPI_FILL_WORD = '0;

endpackage
`default_nettype wire

// File: rtl/spi_slave_shifter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_slave_shifter : oversampled SPI mode-0 slave shift engine     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int                DATA_W    = SPI_DATA_W,
  parameter logic [DATA_W-1:0] FILL_WORD = SPI_FILL_WORD
) (
  input  logic              clk_b,
  input  logic              rst_b_n,
  input  logic              sclk_rise,
  input  logic              sclk_fall,
  input  logic              cs_n_sync,
  input  logic              mosi_sync,
  output logic              miso_o,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              busy
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  spi_state_t        state_q, state_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              seen_q, seen_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              abort_q, abort_d;
  logic              load;
  logic              hs;
  logic [DATA_W-1:0] rx_next;

  assign hs      = tx_valid & ~full_q;
  assign rx_next = {rx_sr_q[DATA_W-2:0], mosi_sync};

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    hold_d     = hold_q;
    rx_data_d  = rx_data_q;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    abort_d    = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!cs_n_sync) begin
          state_d = ACTIVE;
          load    = 1'b1;
          cnt_d   = '0;
          seen_d  = 1'b0;
          rx_sr_d = '0;
        end
      end
      ACTIVE: begin
        // CS deassertion has priority over any SCLK pulse in the same cycle
        if (cs_n_sync) begin
          state_d = IDLE;
          abort_d = (cnt_q != '0);
          cnt_d   = '0;
          rx_sr_d = '0;
        end else begin
          if (sclk_rise) begin
            rx_sr_d = rx_next;
            seen_d  = 1'b1;
            if (cnt_q == CNT_LAST) begin
              cnt_d      = '0;
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if (sclk_fall) begin
            if (cnt_q != '0) begin
              tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
            end else if (seen_q) begin
              load = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (full_q) begin
        tx_sr_d = hold_q;
      end else begin
        tx_sr_d    = FILL_WORD;
        underrun_d = 1'b1;
      end
    end

    // a load takes the old hold word even if a new one is captured this cycle
    full_d = (full_q & ~load) | hs;
    if (hs) begin
      hold_d = tx_data;
    end
  end

  always_ff @(posedge clk_b) begin
    if (!rst_b_n) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      hold_q     <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      seen_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      hold_q     <= hold_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      seen_q     <= seen_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  end

  assign miso_o      = tx_sr_q[DATA_W-1];
  assign miso_oe     = (state_q == ACTIVE);
  assign busy        = (state_q == ACTIVE);
  assign tx_ready    = ~full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_abort = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_shifter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_spi_slave_shifter : scenario bench with a word-level SPI model |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_spi_slave_shifter;
  import spi_pkg::*;

  localparam int W = 8;

  logic         clk_b     = 1'b0;
  logic         rst_b_n   = 1'b0;
  logic         sclk_rise = 1'b0;
  logic         sclk_fall = 1'b0;
  logic         cs_n_sync = 1'b1;
  logic         mosi_sync = 1'b0;
  logic         tx_valid  = 1'b0;
  logic [W-1:0] tx_data   = '0;
  logic         miso_o, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort, busy;
  logic [W-1:0] rx_data;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] rx_q[$];
  int           n_under = 0;
  int           n_abort = 0;

  // word-level model: one-deep hold, each word load consumes it or underruns
  logic         pend_valid = 1'b0;
  logic [W-1:0] pend_word  = '0;
  int           exp_under  = 0;
  logic         last_rv    = 1'b0;

  always #5 clk_b = ~clk_b;

  spi_slave_shifter #(.DATA_W(W), .FILL_WORD(SPI_FILL_WORD)) dut (
    .clk_b(clk_b), .rst_b_n(rst_b_n), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
    .cs_n_sync(cs_n_sync), .mosi_sync(mosi_sync), .miso_o(miso_o), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_underrun(tx_underrun), .frame_abort(frame_abort), .busy(busy)
  );

  always @(negedge clk_b) begin
    if (rx_valid)    rx_q.push_back(rx_data);
    if (tx_underrun) n_under++;
    if (frame_abort) n_abort++;
  end

  function automatic logic [W-1:0] model_load();
    if (pend_valid) begin
      pend_valid = 1'b0;
      return pend_word;
    end
    exp_under++;
    return SPI_FILL_WORD;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_b);
      #1;
    end
  endtask

  task automatic cs_low();
    cs_n_sync = 1'b0;
    cyc(4);
  endtask

  task automatic cs_high();
    cs_n_sync = 1'b1;
    cyc(4);
  endtask

  // one SCLK period; MISO is taken as the master would, just before the rise
  task automatic sclk_bit(input logic b, output logic s);
    mosi_sync = b;
    cyc(2);
    s = miso_o;
    sclk_rise = 1'b1;
    cyc(1);
    sclk_rise = 1'b0;
    last_rv   = rx_valid;
    cyc(3);
    sclk_fall = 1'b1;
    cyc(1);
    sclk_fall = 1'b0;
    cyc(2);
  endtask

  task automatic push_idle(input logic [W-1:0] v);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready got %b want 1", tx_ready);
    end
    tx_data  = v;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid   = 1'b0;
    pend_valid = 1'b1;
    pend_word  = v;
  endtask

  task automatic send_word(input logic [W-1:0] m, input bit do_push, input logic [W-1:0] pv,
                           output logic [W-1:0] mw);
    logic s;
    for (int i = W - 1; i >= 0; i--) begin
      sclk_bit(m[i], s);
      mw[i] = s;
      if (do_push && i == W / 2) begin
        push_idle(pv);
      end
    end
  endtask

  task automatic test_reset();
    rst_b_n = 1'b0;
    cyc(3);
    checks += 8;
    if (miso_o !== 1'b0)      begin errors++; $display("FAIL rst_miso got %b want 0", miso_o); end
    if (miso_oe !== 1'b0)     begin errors++; $display("FAIL rst_miso_oe got %b want 0", miso_oe); end
    if (tx_ready !== 1'b1)    begin errors++; $display("FAIL rst_tx_ready got %b want 1", tx_ready); end
    if (rx_data !== '0)       begin errors++; $display("FAIL rst_rx_data got %h want 00", rx_data); end
    if (rx_valid !== 1'b0)    begin errors++; $display("FAIL rst_rx_valid got %b want 0", rx_valid); end
    if (tx_underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b want 0", tx_underrun); end
    if (frame_abort !== 1'b0) begin errors++; $display("FAIL rst_abort got %b want 0", frame_abort); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    rst_b_n = 1'b1;
    cyc(3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [W-1:0] e, mw, d;
    int r0, u0, eu0;
    r0 = rx_q.size(); u0 = n_under; eu0 = exp_under;
    push_idle(8'hA5);
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL basic_full got %b want 0", tx_ready); end
    e = model_load();
    cs_low();
    checks += 4;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", tx_ready); end
    if (busy !== 1'b1)     begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    if (miso_oe !== 1'b1)  begin errors++; $display("FAIL basic_oe got %b want 1", miso_oe); end
    if (miso_o !== e[W-1]) begin errors++; $display("FAIL basic_first_bit got %b want %b", miso_o, e[W-1]); end
    send_word(8'h3C, 1'b0, '0, mw);
    checks += 2;
    if (mw !== e)          begin errors++; $display("FAIL basic_miso got %h want %h", mw, e); end
    if (last_rv !== 1'b1)  begin errors++; $display("FAIL basic_rx_latency got %b want 1", last_rv); end
    d = model_load();
    cs_high();
    checks += 3;
    if (rx_q.size() !== r0 + 1) begin
      errors++; $display("FAIL basic_rx_count got %0d want %0d", rx_q.size() - r0, 1);
    end else if (rx_q[r0] !== 8'h3C) begin
      errors++; $display("FAIL basic_rx_data got %h want 3c", rx_q[r0]);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", busy); end
    if (n_under - u0 !== exp_under - eu0) begin
      errors++; $display("FAIL basic_underrun got %0d want %0d", n_under - u0, exp_under - eu0);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e1, e2, m1, m2, d;
    int r0, u0;
    r0 = rx_q.size(); u0 = n_under;
    push_idle(8'h11);
    e1 = model_load();
    cs_low();
    send_word(8'hF0, 1'b1, 8'h22, m1);
    e2 = model_load();
    send_word(8'h0F, 1'b1, 8'h33, m2);
    d = model_load();
    cs_high();
    checks += 4;
    if (m1 !== e1) begin errors++; $display("FAIL b2b_miso0 got %h want %h", m1, e1); end
    if (m2 !== e2) begin errors++; $display("FAIL b2b_miso1 got %h want %h", m2, e2); end
    if (rx_q.size() !== r0 + 2) begin
      errors++; $display("FAIL b2b_rx_count got %0d want 2", rx_q.size() - r0);
    end else if (rx_q[r0] !== 8'hF0 || rx_q[r0+1] !== 8'h0F) begin
      errors++; $display("FAIL b2b_rx_data got %h %h want f0 0f", rx_q[r0], rx_q[r0+1]);
    end
    if (n_under !== u0) begin errors++; $display("FAIL b2b_underrun got %0d want 0", n_under - u0); end
  endtask

  task automatic test_underrun();
    logic [W-1:0] e, mw, d;
    int r0, u0, eu0;
    r0 = rx_q.size(); u0 = n_under; eu0 = exp_under;
    e = model_load();
    cs_low();
    checks++;
    if (n_under - u0 !== 1) begin errors++; $display("FAIL udr_pulse got %0d want 1", n_under - u0); end
    send_word(8'h81, 1'b0, '0, mw);
    d = model_load();
    cs_high();
    checks += 3;
    if (mw !== e) begin errors++; $display("FAIL udr_miso got %h want %h", mw, e); end
    if (rx_q.size() !== r0 + 1 || rx_q[$] !== 8'h81) begin
      errors++; $display("FAIL udr_rx got %h want 81", rx_data);
    end
    if (n_under - u0 !== exp_under - eu0) begin
      errors++; $display("FAIL udr_total got %0d want %0d", n_under - u0, exp_under - eu0);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] e, mw, d;
    logic s;
    int r0, a0;
    r0 = rx_q.size(); a0 = n_abort;
    e = model_load();
    cs_low();
    for (int i = 0; i < 5; i++) sclk_bit(1'($urandom), s);
    cs_high();
    checks += 2;
    if (n_abort - a0 !== 1)     begin errors++; $display("FAIL abort_pulse got %0d want 1", n_abort - a0); end
    if (rx_q.size() !== r0)     begin errors++; $display("FAIL abort_rx got %0d want 0", rx_q.size() - r0); end
    e = model_load();
    cs_low();
    send_word(8'h55, 1'b0, '0, mw);
    d = model_load();
    cs_high();
    checks += 3;
    if (mw !== e) begin errors++; $display("FAIL abort_next_miso got %h want %h", mw, e); end
    if (rx_q.size() !== r0 + 1 || rx_data !== 8'h55) begin
      errors++; $display("FAIL abort_next_rx got %h want 55", rx_data);
    end
    if (n_abort - a0 !== 1) begin errors++; $display("FAIL abort_clean got %0d want 1", n_abort - a0); end
  endtask

  task automatic test_race();
    logic [W-1:0] e;
    logic s;
    int r0, a0;
    r0 = rx_q.size(); a0 = n_abort;
    e = model_load();
    cs_low();
    for (int i = 0; i < W - 1; i++) sclk_bit(1'($urandom), s);
    mosi_sync = 1'b1;
    cyc(2);
    sclk_rise = 1'b1;
    cs_n_sync = 1'b1;
    cyc(1);
    sclk_rise = 1'b0;
    cyc(4);
    checks += 3;
    if (rx_q.size() !== r0) begin errors++; $display("FAIL race_rx got %0d want 0", rx_q.size() - r0); end
    if (n_abort - a0 !== 1) begin errors++; $display("FAIL race_abort got %0d want 1", n_abort - a0); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL race_busy got %b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] e, mw, d;
    logic s;
    int r0, u0, eu0;
    push_idle(8'h9E);
    e = model_load();
    cs_low();
    for (int i = 0; i < 3; i++) sclk_bit(1'($urandom), s);
    push_idle(8'h77);
    rst_b_n = 1'b0;
    cyc(2);
    pend_valid = 1'b0;
    checks += 6;
    if (miso_oe !== 1'b0)  begin errors++; $display("FAIL mrst_oe got %b want 0", miso_oe); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL mrst_busy got %b want 0", busy); end
    if (miso_o !== 1'b0)   begin errors++; $display("FAIL mrst_miso got %b want 0", miso_o); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready got %b want 1", tx_ready); end
    if (rx_data !== '0)    begin errors++; $display("FAIL mrst_rx_data got %h want 00", rx_data); end
    if (rx_valid !== 1'b0 || tx_underrun !== 1'b0 || frame_abort !== 1'b0) begin
      errors++; $display("FAIL mrst_pulses got %b%b%b want 000", rx_valid, tx_underrun, frame_abort);
    end
    r0 = rx_q.size(); u0 = n_under; eu0 = exp_under;
    rst_b_n = 1'b1;
    e = model_load();
    cyc(4);
    send_word(8'hC3, 1'b0, '0, mw);
    d = model_load();
    cs_high();
    checks += 3;
    if (mw !== e) begin errors++; $display("FAIL mrst_miso_word got %h want %h", mw, e); end
    if (rx_q.size() !== r0 + 1 || rx_data !== 8'hC3) begin
      errors++; $display("FAIL mrst_rx got %h want c3", rx_data);
    end
    if (n_under - u0 !== exp_under - eu0) begin
      errors++; $display("FAIL mrst_underrun got %0d want %0d", n_under - u0, exp_under - eu0);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_rx[$];
    logic [W-1:0] e, m, mw, pv;
    int r0, a0, nw;
    bit dp;
    r0 = rx_q.size(); a0 = n_abort;
    for (int f = 0; f < 12; f++) begin
      nw = $urandom_range(1, 3);
      if (!pend_valid && $urandom_range(0, 1) == 1) push_idle(W'($urandom));
      e = model_load();
      cs_low();
      for (int k = 0; k < nw; k++) begin
        m  = W'($urandom);
        pv = W'($urandom);
        dp = ($urandom_range(0, 1) == 1) && !pend_valid;
        send_word(m, dp, pv, mw);
        exp_rx.push_back(m);
        checks++;
        if (mw !== e) begin errors++; $display("FAIL rnd_miso f%0d w%0d got %h want %h", f, k, mw, e); end
        e = model_load();
      end
      cs_high();
    end
    checks += 3;
    if (rx_q.size() - r0 !== exp_rx.size()) begin
      errors++; $display("FAIL rnd_rx_count got %0d want %0d", rx_q.size() - r0, exp_rx.size());
    end else begin
      for (int i = 0; i < exp_rx.size(); i++) begin
        if (rx_q[r0+i] !== exp_rx[i]) begin
          errors++; $display("FAIL rnd_rx_data idx %0d got %h want %h", i, rx_q[r0+i], exp_rx[i]);
          break;
        end
      end
    end
    if (n_abort !== a0)      begin errors++; $display("FAIL rnd_abort got %0d want 0", n_abort - a0); end
    if (n_under !== exp_under) begin errors++; $display("FAIL rnd_underrun got %0d want %0d", n_under, exp_under); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_race();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
